// File: rtl/freq_meter_pkg.sv
// Shared constants and FSM state type for the frequency meter.
package freq_meter_pkg;

    localparam int unsigned FM_CLK_HZ      = 50_000_000;
    localparam int unsigned FM_GATE_CYCLES = FM_CLK_HZ;
    localparam int unsigned FM_CNT_W       = 27;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LATCH   = 2'd3
    } fm_state_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a third flop
// giving a single-cycle rising-edge strobe.
module sync_edge
    import freq_meter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts synchronized rising edges of i_sig_in
// over GATE_CYCLES clocks and publishes the saturating count with a valid pulse.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = FM_CLK_HZ,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = FM_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sig_in,
    output logic [CNT_W-1:0] o_freq,
    output logic             o_freq_valid,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int unsigned        GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    fm_state_t         r_state;
    fm_state_t         w_state_nxt;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic [CNT_W-1:0]  w_edge_nxt;
    logic              r_ovf_flag;
    logic              w_ovf_nxt;
    logic              w_rise;
    logic              w_gate_done;
    logic [CNT_W-1:0]  r_freq;
    logic              r_ovf;
    logic              r_freq_valid;

    sync_edge u_sync_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_sig_in),
        .o_rise  (w_rise)
    );

    assign w_gate_done = (r_gate_cnt == GATE_LAST);

    always_comb begin
        w_edge_nxt = r_edge_cnt;
        w_ovf_nxt  = r_ovf_flag;
        if (w_rise) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_edge_nxt = r_edge_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:    w_state_nxt = i_en ? ST_ARM : ST_IDLE;
            ST_ARM:     w_state_nxt = i_en ? ST_MEASURE : ST_IDLE;
            ST_MEASURE: w_state_nxt = !i_en       ? ST_IDLE  :
                                      w_gate_done ? ST_LATCH : ST_MEASURE;
            ST_LATCH:   w_state_nxt = i_en ? ST_ARM : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // The result is captured on the edge entering LATCH, using the next-count
    // value so a rise in the final gate cycle is included and freq/freq_valid
    // are both visible during the LATCH cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_ovf_flag   <= 1'b0;
            r_freq       <= '0;
            r_ovf        <= 1'b0;
            r_freq_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_freq_valid <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf_flag <= 1'b0;
                end
                ST_MEASURE: begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    r_edge_cnt <= w_edge_nxt;
                    r_ovf_flag <= w_ovf_nxt;
                    if (i_en && w_gate_done) begin
                        r_freq       <= w_edge_nxt;
                        r_ovf        <= w_ovf_nxt;
                        r_freq_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_freq       = r_freq;
    assign o_ovf        = r_ovf;
    assign o_freq_valid = r_freq_valid;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: 100-cycle gate, 8-bit and 4-bit counter instances.
module tb_freq_meter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en8;
    logic       en4;
    logic       sig;
    logic [7:0] freq8;
    logic       v8, ovf8, busy8;
    logic [3:0] freq4;
    logic       v4, ovf4, busy4;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   period = 0;
    int   ph     = 0;
    logic manual = 1'b0;

    freq_meter #(.CLK_HZ(100), .GATE_CYCLES(100), .CNT_W(8)) dut8 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en8),
        .i_sig_in     (sig),
        .o_freq       (freq8),
        .o_freq_valid (v8),
        .o_ovf        (ovf8),
        .o_busy       (busy8)
    );

    freq_meter #(.CLK_HZ(100), .GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en4),
        .i_sig_in     (sig),
        .o_freq       (freq4),
        .o_freq_valid (v4),
        .o_ovf        (ovf4),
        .o_busy       (busy4)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Stimulus source: period 0 follows the manual level, otherwise a square wave.
    initial begin
        sig = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ph = ph + 1;
            if (period == 0) sig = manual;
            else             sig = ((ph % period) < (period / 2));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!v8 && cyc < 400);
        chk("valid_seen", 32'(v8), 1);
    endtask

    initial begin
        int cyc;
        int nv;
        rst_n = 1'b0;
        en8   = 1'b0;
        en4   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_freq",  32'(freq8), 0);
        chk("rst_valid", 32'(v8),    0);
        chk("rst_ovf",   32'(ovf8),  0);
        chk("rst_busy",  32'(busy8), 0);
        chk("rst_freq4", 32'(freq4), 0);
        chk("rst_busy4", 32'(busy4), 0);

        rst_n  = 1'b1;
        period = 10;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy8), 0);

        en8 = 1'b1;
        wait_valid(cyc);
        chk("first_latency", cyc, 102);
        chk("p10_freq", 32'(freq8), 10);
        chk("p10_ovf",  32'(ovf8),  0);
        chk("latch_busy", 32'(busy8), 1);
        wait_valid(cyc);
        chk("gate_spacing", cyc, 102);
        chk("p10_freq2", 32'(freq8), 10);
        @(negedge clk);
        chk("valid_one_cycle", 32'(v8), 0);

        period = 0;
        wait_valid(cyc);
        wait_valid(cyc);
        chk("const0_freq", 32'(freq8), 0);
        chk("const0_ovf",  32'(ovf8),  0);

        period = 2;
        wait_valid(cyc);
        en4 = 1'b1;
        wait_valid(cyc);
        chk("p2_freq",     32'(freq8), 50);
        chk("w4_valid",    32'(v4),    1);
        chk("w4_sat_freq", 32'(freq4), 15);
        chk("w4_sat_ovf",  32'(ovf4),  1);

        period = 20;
        wait_valid(cyc);
        chk("w4_valid2",    32'(v4),   1);
        chk("w4_ovf_clear", 32'(ovf4), 0);
        wait_valid(cyc);
        chk("p20_freq",    32'(freq8), 5);
        chk("w4_p20_freq", 32'(freq4), 5);
        chk("w4_p20_ovf",  32'(ovf4),  0);

        en4    = 1'b0;
        period = 10;
        wait_valid(cyc);
        wait_valid(cyc);
        chk("p10_again", 32'(freq8), 10);

        repeat (42) @(negedge clk);
        chk("measure_busy", 32'(busy8), 1);
        en8 = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy8), 0);
        nv = 0;
        repeat (150) begin
            @(negedge clk);
            if (v8) nv++;
        end
        chk("abort_no_valid", nv, 0);
        chk("abort_freq", 32'(freq8), 10);
        chk("abort_ovf",  32'(ovf8),  0);

        en8 = 1'b1;
        repeat (50) @(negedge clk);
        rst_n  = 1'b0;
        period = 0;
        manual = 1'b0;
        @(negedge clk);
        chk("mid_rst_freq",  32'(freq8), 0);
        chk("mid_rst_ovf",   32'(ovf8),  0);
        chk("mid_rst_busy",  32'(busy8), 0);
        chk("mid_rst_valid", 32'(v8),    0);
        rst_n = 1'b1;
        wait_valid(cyc);
        chk("post_rst_latency", cyc, 102);
        chk("post_rst_freq", 32'(freq8), 0);

        // Rise applied so it reaches the edge detector on the last gate cycle.
        repeat (98) @(negedge clk);
        manual = 1'b1;
        wait_valid(cyc);
        chk("last_cycle_latency", cyc, 4);
        chk("last_cycle_rise", 32'(freq8), 1);
        wait_valid(cyc);
        chk("const1_freq", 32'(freq8), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter GATE_CYCLES, default CLK_HZ, gate window length in clk cycles (1 s at default).
REQ-003 Parameter CNT_W, default 27, width of the edge counter and of the result.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 en  input  1  measurement enable; level-sensitive.
REQ-007 sig_in  input  1  asynchronous signal under measurement.
REQ-008 freq  output  CNT_W  rising edges counted in the last completed gate (Hz at default gate).
REQ-009 freq_valid  output  1  one-cycle pulse when freq updates.
REQ-010 ovf  output  1  last completed gate saturated the counter.
REQ-011 busy  output  1  high in ARM, MEASURE and LATCH.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer, then a third flop for edge detect; rise = sync & ~prev.
REQ-013 FSM states SHALL be IDLE, ARM, MEASURE, LATCH.
REQ-014 IDLE: hold freq/ovf; go to ARM when en=1.
REQ-015 ARM: one cycle; clear gate counter and edge counter to 0; go to MEASURE.
REQ-016 MEASURE: gate counter increments each cycle; rise increments edge counter; lasts exactly GATE_CYCLES cycles.
REQ-017 A rise in the final MEASURE cycle SHALL be counted.
REQ-018 Edge counter SHALL saturate at 2^CNT_W-1; any further rise sets an internal overflow flag.
REQ-019 LATCH: one cycle; freq <= edge counter, ovf <= overflow flag, freq_valid=1; next ARM if en=1, else IDLE.
REQ-020 Latency from ARM entry to freq_valid SHALL be GATE_CYCLES+1 cycles; back-to-back gates spaced GATE_CYCLES+2 cycles.
REQ-021 en deasserted during MEASURE SHALL abort to IDLE next cycle; no freq_valid; freq/ovf keep previous values.
REQ-022 en deasserted during ARM SHALL go to IDLE; during LATCH the latch completes, then IDLE.
REQ-023 Rises during IDLE, ARM and LATCH SHALL be ignored.
REQ-024 Input frequencies above CLK_HZ/2 are out of range; the count is undefined but ovf rules still hold.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force IDLE, freq=0, freq_valid=0, ovf=0, busy=0, all counters and synchronizer flops 0.
REQ-026 Reset mid-MEASURE SHALL discard the partial count; no freq_valid.
REQ-027 After rst_n rises with en=1, ARM SHALL be entered on the first clk edge.

Structure
REQ-028 Package freq_meter_pkg holds the state enum and default CLK_HZ/GATE_CYCLES/CNT_W constants.
REQ-029 One sub-module sync_edge (synchronizer + rising-edge detect) SHALL be instantiated for sig_in.
REQ-030 Gate counter width = clog2(GATE_CYCLES); no derived clocks; single clock domain.

Verification (GATE_CYCLES=100, CNT_W=8 unless noted)
REQ-031 sig_in period 10 clk, en=1 -> freq_valid every 102 cycles, freq=10, ovf=0.
REQ-032 sig_in constant 0 -> freq=0 on every valid pulse; sig_in toggling each clk (period 2) -> freq=50.
REQ-033 CNT_W=4, period 2 -> freq=15, ovf=1; next gate at period 20 -> freq=5, ovf=0.
REQ-034 en dropped 40 cycles into MEASURE -> no freq_valid, freq keeps prior 10, busy=0 within 1 cycle.
REQ-035 rst_n low for 1 cycle mid-MEASURE -> freq=0, ovf=0, IDLE; with en=1 the first valid arrives 102 cycles after release.
REQ-036 Single rise aligned to the final MEASURE cycle -> freq=1.
